pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined adder/subtractor that supersedes the fixed 4-bit ripple adder for datapath use.
- Operands of WIDTH bits are split into CHUNK-bit slices; each pipeline stage resolves one slice and registers the carry into the next stage.
- Throughput is one operation per cycle, with a valid/ready handshake on both sides.
- Outputs are sum, carry/borrow out and signed overflow. Sits between operand registers and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op  in  1  0 = add, 1 = subtract.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB of internal adder.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Arithmetic:
  - add: sum = a + b + cin.
  - sub: sum = a + ~b + ~cin, i.e. a - b - cin.
  - cout is the raw carry out of the internal adder. For sub, cout = 0 means a borrow occurred.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is b after inversion.
  - Results are truncated to WIDTH; no saturation.
- Pipeline:
  - Stage k (0..STAGES-1) computes slice k from registered slice operands plus the carry registered by stage k-1.
  - Upper slices of a/b/op travel skewed through delay registers; completed lower sum slices travel de-skewed forward.
  - Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES (4 cycles at defaults).
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - Accept occurs on in_valid && in_ready.
  - All stage registers, including per-stage valid bits, move only when advance=1. When advance=0 the whole pipe holds.
  - Bubbles propagate as valid=0 stages. Bubbles are not compressed.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold exactly.
- Reset:
  - All valid bits clear, so out_valid=0 on the cycle after rst is sampled high. sum, cout and ovf read 0.
  - in_ready=1 during the first post-reset cycle.
  - In-flight beats are discarded, with no partial output.
  - rst has priority over any simultaneous accept.
- Simultaneous events: accept and output consumption in the same cycle are legal and sustain full rate. in_valid with in_ready=0 has no effect; the source must hold the beat.
- Degenerate case: CHUNK == WIDTH gives a single-stage registered adder with latency 1.

Decomposition:
- Shared package addsub_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants.
  - A function computing STAGES from WIDTH/CHUNK.
  - A compile-time check that WIDTH % CHUNK == 0.
- One sub-module, addsub_chunk: CHUNK-bit combinational slice adder taking a_slice, b_slice, carry_in and producing sum_slice, carry_out and msb_carry_in (for overflow). It is instantiated STAGES times by a generate loop.

Test Plan (WIDTH=16, CHUNK=4, out_ready=1 unless stated):
- Add 0x1234+0x4321, cin=0 -> 4 cycles later sum=0x5555, cout=0, ovf=0.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. This checks the carry passing through all four stages.
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Then sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Repeat with cin=1 -> sum=0xFFFD.
- Issue 6 back-to-back beats, then hold out_ready=0 for 3 cycles after the first result. Required:
  - in_ready drops in the same cycles.
  - The held output is stable.
  - All 6 results arrive in order with none lost or duplicated.
  - Full rate resumes afterwards.
- Assert rst for one cycle while 3 beats are in flight -> out_valid=0 from the next cycle. No stale result appears. A fresh beat afterwards returns after exactly 4 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// One CHUNK-bit slice of the adder; also exposes the carry into its MSB so the
// top slice can flag signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_slice,
    input  logic [CHUNK-1:0] b_slice,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum_slice,
    output logic             carry_out,
    output logic             msb_carry_in
);

    logic [CHUNK:0] total;

    assign total        = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_in};
    assign sum_slice    = total[CHUNK-1:0];
    assign carry_out    = total[CHUNK];
    assign msb_carry_in = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ sum_slice[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit slice resolved per stage, carry registered
// between stages, whole pipe stalls together under a valid/ready handshake.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] a0_d, a0_q, bx0_d, bx0_q;
    logic             c0_d, c0_q, vld0_d, vld0_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, out_vld_d, out_vld_q;

    assign advance  = !out_vld_q || out_ready;
    assign in_ready = advance;

    // Input register: subtraction is folded in here as a + ~b + ~cin.
    always_comb begin
        a0_d   = a0_q;
        bx0_d  = bx0_q;
        c0_d   = c0_q;
        vld0_d = vld0_q;
        if (advance) begin
            a0_d   = a;
            bx0_d  = (op == OP_SUB) ? ~b : b;
            c0_d   = (op == OP_SUB) ? ~cin : cin;
            vld0_d = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld0_q <= 1'b0;
        else     vld0_q <= vld0_d;
        a0_q  <= a0_d;
        bx0_q <= bx0_d;
        c0_q  <= c0_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]      a_in, bx_in;
        logic [LO+CHUNK-1:0] s_cat;
        logic                c_in, vld_in;
        logic [CHUNK-1:0]    s_slice;
        logic                c_out, c_msb;

        if (k == 0) begin : g_src
            assign a_in   = a0_q;
            assign bx_in  = bx0_q;
            assign c_in   = c0_q;
            assign vld_in = vld0_q;
            assign s_cat  = s_slice;
        end else begin : g_src
            assign a_in   = g_stg[k-1].g_mid.a_q;
            assign bx_in  = g_stg[k-1].g_mid.bx_q;
            assign c_in   = g_stg[k-1].g_mid.c_q;
            assign vld_in = g_stg[k-1].g_mid.vld_q;
            assign s_cat  = {s_slice, g_stg[k-1].g_mid.s_q};
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_slice      (a_in[CHUNK-1:0]),
            .b_slice      (bx_in[CHUNK-1:0]),
            .carry_in     (c_in),
            .sum_slice    (s_slice),
            .carry_out    (c_out),
            .msb_carry_in (c_msb)
        );

        // Stage boundary: unresolved upper operand bits move skewed, finished sum bits de-skewed.
        if (k < STAGES - 1) begin : g_mid
            logic [REM-CHUNK-1:0] a_d, a_q, bx_d, bx_q;
            logic [LO+CHUNK-1:0]  s_d, s_q;
            logic                 c_d, c_q, vld_d, vld_q;
            logic                 unused_msb;

            assign unused_msb = c_msb;

            always_comb begin
                a_d   = a_q;
                bx_d  = bx_q;
                s_d   = s_q;
                c_d   = c_q;
                vld_d = vld_q;
                if (advance) begin
                    a_d   = a_in[REM-1:CHUNK];
                    bx_d  = bx_in[REM-1:CHUNK];
                    s_d   = s_cat;
                    c_d   = c_out;
                    vld_d = vld_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) vld_q <= 1'b0;
                else     vld_q <= vld_d;
                a_q  <= a_d;
                bx_q <= bx_d;
                s_q  <= s_d;
                c_q  <= c_d;
            end
        end
    end

    // Output register fed by the top slice; overflow is carry-in vs carry-out of the MSB.
    always_comb begin
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;
        if (advance) begin
            sum_d     = g_stg[STAGES-1].s_cat;
            cout_d    = g_stg[STAGES-1].c_out;
            ovf_d     = g_stg[STAGES-1].c_out ^ g_stg[STAGES-1].c_msb;
            out_vld_d = g_stg[STAGES-1].vld_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) out_vld_q <= 1'b0;
        else     out_vld_q <= out_vld_d;
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
    end

    assign out_valid = out_vld_q;
    assign sum       = out_vld_q ? sum_q : '0;
    assign cout      = out_vld_q & cout_q;
    assign ovf       = out_vld_q & ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: driver pushes reference results, a
// negedge monitor pops and compares whenever a result is presented.
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               exp_cyc;
        bit               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             op = 1'b0;
    logic             cin = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready, out_valid, cout, ovf;
    logic [WIDTH-1:0] sum;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   rand_done = 0;

    pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic c);
        exp_t e;
        int   r, s;
        if (o) begin
            r = int'(x) - int'(y) - int'(c);
            s = int'($signed(x)) - int'($signed(y)) - int'(c);
            e.cout = (r >= 0);
        end else begin
            r = int'(x) + int'(y) + int'(c);
            s = int'($signed(x)) + int'($signed(y)) + int'(c);
            e.cout = (r >= (1 << WIDTH));
        end
        e.sum     = r[WIDTH-1:0];
        e.ovf     = (s >= (1 << (WIDTH-1))) || (s < -(1 << (WIDTH-1)));
        e.exp_cyc = 0;
        e.lat     = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input bit lat);
        int   guard = 0;
        bit   acc = 0;
        exp_t e;
        op = o; a = x; b = y; cin = c; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e = model(o, x, y, c);
                e.exp_cyc = cyc + STAGES + 1;
                e.lat = lat;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 100) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                chk("sum", 32'(sum), 32'(exp_q[0].sum));
                chk("cout", 32'(cout), 32'(exp_q[0].cout));
                chk("ovf", 32'(ovf), 32'(exp_q[0].ovf));
                if (out_ready) begin
                    if (exp_q[0].lat) chk("latency", 32'(cyc), 32'(exp_q[0].exp_cyc));
                    void'(exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] da [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005, 16'hFFFF};
        logic [WIDTH-1:0] db [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0000};
        logic             dop[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic             dci[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int               base;
        int               guard;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send(dop[i], da[i], db[i], dci[i], 1'b1);
            drain();
        end

        // Six back-to-back beats with a three-cycle output stall after the first result.
        base = pop_cyc.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                chk("stall_first_result", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 32'(pop_cyc.size() - base), 32'd6);
        for (int k = base + 2; k < base + 6 && k < pop_cyc.size(); k++)
            chk("full_rate_after_stall", 32'(pop_cyc[k] - pop_cyc[k-1]), 32'd1);

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) send(1'b0, pick(), pick(), 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1);
        drain();

        // Randomised traffic with random source gaps and sink back-pressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
